// File: rtl/pool_pkg.sv
// Shared types and defaults for the pooling window producer.
// Window index helper maps (row, col) to raster position.
package pool_pkg;

    localparam int DEF_NUM_CHANNELS = 6;
    localparam int DEF_DATA_WIDTH   = 6;
    localparam int DEF_MATRIX_DIM   = 3;
    localparam int DEF_IMG_WIDTH    = 12;
    localparam int DEF_IMG_HEIGHT   = 12;

    localparam int DEF_PIX_W = DEF_NUM_CHANNELS * DEF_DATA_WIDTH;
    localparam int DEF_WIN_W = DEF_PIX_W * DEF_MATRIX_DIM * DEF_MATRIX_DIM;

    typedef logic [DEF_PIX_W-1:0] pixel_t;
    typedef logic [DEF_WIN_W-1:0] window_t;

    function automatic int win_index(input int win_row,
                                     input int win_col,
                                     input int wins_per_row);
        return win_row * wins_per_row + win_col;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Row storage for the first MATRIX_DIM-1 rows of a window band.
// One write port, one read port per slot, all sharing a column address.
module pool_line_buffer
    import pool_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int SLOTS = DEF_MATRIX_DIM - 1,
    parameter int DEPTH = DEF_IMG_WIDTH,
    parameter int SLW   = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [SLW-1:0]         wr_slot,
    input  logic [AW-1:0]          wr_col,
    input  logic [PIX_W-1:0]       wr_data,
    input  logic [AW-1:0]          rd_col,
    output logic [SLOTS*PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [SLOTS][DEPTH];

    // Store one pixel into its row slot; contents need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_slot][wr_col] <= wr_data;
        end
    end

    // Present the same column of every buffered row in parallel.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < SLOTS; r++) begin
            rd_data[r*PIX_W +: PIX_W] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/pool_window_gen.sv
// Raster pixel stream in, non-overlapping pooling windows out.
// Buffers MATRIX_DIM-1 rows plus a column history on the last band row.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int MATRIX_DIM   = DEF_MATRIX_DIM,
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   s_valid,
    output logic                                                   s_ready,
    input  logic                                                   s_sof,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]                     s_data,
    output logic                                                   m_valid,
    input  logic                                                   m_ready,
    output logic [NUM_CHANNELS*MATRIX_DIM*MATRIX_DIM*DATA_WIDTH-1:0] m_data,
    output logic [$clog2(IMG_WIDTH/MATRIX_DIM)-1:0]                m_win_col,
    output logic [$clog2(IMG_HEIGHT/MATRIX_DIM)-1:0]               m_win_row,
    output logic                                                   frame_done
);

    localparam int M     = MATRIX_DIM;
    localparam int DW    = DATA_WIDTH;
    localparam int PIX_W = NUM_CHANNELS * DW;
    localparam int WIN_W = PIX_W * M * M;
    localparam int WCOLS = IMG_WIDTH / M;
    localparam int WROWS = IMG_HEIGHT / M;
    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int SW    = $clog2(M);
    localparam int WCW   = $clog2(WCOLS);
    localparam int WRW   = $clog2(WROWS);
    localparam int LBSW  = (M - 1 > 1) ? $clog2(M - 1) : 1;

    if (IMG_WIDTH % MATRIX_DIM != 0) begin : g_bad_width
        $error("IMG_WIDTH must be a multiple of MATRIX_DIM");
    end
    if (IMG_HEIGHT % MATRIX_DIM != 0) begin : g_bad_height
        $error("IMG_HEIGHT must be a multiple of MATRIX_DIM");
    end
    if (MATRIX_DIM < 2) begin : g_bad_dim
        $error("MATRIX_DIM must be at least 2");
    end

    logic [SW-1:0]  col_sub_q, col_sub_d, eff_col_sub;
    logic [SW-1:0]  row_sub_q, row_sub_d, eff_row_sub;
    logic [WCW-1:0] win_col_q, win_col_d, eff_win_col;
    logic [WRW-1:0] win_row_q, win_row_d, eff_win_row;

    logic            accept;
    logic            last_k;
    logic            last_r;
    logic            win_fire;
    logic            frame_end;
    logic [CW-1:0]   col_addr;
    logic [LBSW-1:0] lb_slot;
    logic            lb_we;

    logic [(M-1)*PIX_W-1:0] lb_rd;
    logic [M*PIX_W-1:0]     cur_col;
    logic [M*PIX_W-1:0]     colbuf_q [M-1];
    logic [M*PIX_W-1:0]     colbuf_d [M-1];
    logic [WIN_W-1:0]       win_asm;

    logic             m_valid_q, m_valid_d;
    logic [WIN_W-1:0] m_data_q, m_data_d;
    logic [WCW-1:0]   m_win_col_q, m_win_col_d;
    logic [WRW-1:0]   m_win_row_q, m_win_row_d;
    logic             frame_done_q, frame_done_d;

    assign s_ready = !(m_valid_q && !m_ready);

    // Resolve where the incoming pixel lands; s_sof forces (0,0).
    always_comb begin
        accept      = s_valid && s_ready;
        eff_col_sub = s_sof ? '0 : col_sub_q;
        eff_row_sub = s_sof ? '0 : row_sub_q;
        eff_win_col = s_sof ? '0 : win_col_q;
        eff_win_row = s_sof ? '0 : win_row_q;
        last_k      = (eff_col_sub == SW'(M - 1));
        last_r      = (eff_row_sub == SW'(M - 1));
        win_fire    = accept && last_k && last_r;
        frame_end   = win_fire
                   && (eff_win_col == WCW'(WCOLS - 1))
                   && (eff_win_row == WRW'(WROWS - 1));
        col_addr    = CW'(int'(eff_win_col) * M + int'(eff_col_sub));
        lb_slot     = LBSW'(eff_row_sub);
        lb_we       = accept && !last_r;
    end

    // Step the raster position after each accepted pixel.
    always_comb begin
        col_sub_d = col_sub_q;
        row_sub_d = row_sub_q;
        win_col_d = win_col_q;
        win_row_d = win_row_q;
        if (accept) begin
            col_sub_d = eff_col_sub;
            row_sub_d = eff_row_sub;
            win_col_d = eff_win_col;
            win_row_d = eff_win_row;
            if (!last_k) begin
                col_sub_d = eff_col_sub + 1'b1;
            end else begin
                col_sub_d = '0;
                if (eff_win_col != WCW'(WCOLS - 1)) begin
                    win_col_d = eff_win_col + 1'b1;
                end else begin
                    win_col_d = '0;
                    if (!last_r) begin
                        row_sub_d = eff_row_sub + 1'b1;
                    end else begin
                        row_sub_d = '0;
                        win_row_d = (eff_win_row == WRW'(WROWS - 1))
                                  ? '0 : eff_win_row + 1'b1;
                    end
                end
            end
        end
    end

    pool_line_buffer #(
        .PIX_W (PIX_W),
        .SLOTS (M - 1),
        .DEPTH (IMG_WIDTH),
        .SLW   (LBSW),
        .AW    (CW)
    ) u_line_buffer (
        .clk     (clk),
        .we      (lb_we),
        .wr_slot (lb_slot),
        .wr_col  (col_addr),
        .wr_data (s_data),
        .rd_col  (col_addr),
        .rd_data (lb_rd)
    );

    assign cur_col = {s_data, lb_rd};

    // Shift whole window columns in while walking the band's last row.
    always_comb begin
        colbuf_d = colbuf_q;
        if (accept && last_r && !last_k) begin
            for (int i = 0; i < M - 2; i++) begin
                colbuf_d[i] = colbuf_q[i + 1];
            end
            colbuf_d[M-2] = cur_col;
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        for (genvar r = 0; r < M; r++) begin : g_row
            for (genvar k = 0; k < M; k++) begin : g_col
                localparam int DST = ((c * M * M) + r * M + k) * DW;
                localparam int SRC = r * PIX_W + c * DW;
                if (k < M - 1) begin : g_hist
                    assign win_asm[DST +: DW] = colbuf_q[k][SRC +: DW];
                end else begin : g_live
                    assign win_asm[DST +: DW] = cur_col[SRC +: DW];
                end
            end
        end
    end

    // Load a finished window or hold the current one under backpressure.
    always_comb begin
        m_valid_d    = m_valid_q && !m_ready;
        m_data_d     = m_data_q;
        m_win_col_d  = m_win_col_q;
        m_win_row_d  = m_win_row_q;
        frame_done_d = frame_end;
        if (win_fire) begin
            m_valid_d   = 1'b1;
            m_data_d    = win_asm;
            m_win_col_d = eff_win_col;
            m_win_row_d = eff_win_row;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_sub_q    <= '0;
            row_sub_q    <= '0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_win_col_q  <= '0;
            m_win_row_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_sub_q    <= col_sub_d;
            row_sub_q    <= row_sub_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_win_col_q  <= m_win_col_d;
            m_win_row_q  <= m_win_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Column history is always rewritten before use.
    always_ff @(posedge clk) begin
        colbuf_q <= colbuf_d;
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_win_col  = m_win_col_q;
    assign m_win_row  = m_win_row_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: frame-image model plus directed streams.
// Window expectations are cut from a stored copy of the frame.
module tb_pool_window_gen;
    import pool_pkg::*;

    localparam int W  = 12;
    localparam int H  = 12;
    localparam int NP = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_sof = 1'b0;
    pixel_t        s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    window_t       m_data;
    logic [1:0]    m_win_col;
    logic [1:0]    m_win_row;
    logic          frame_done;

    pool_window_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sof      (s_sof),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_win_col  (m_win_col),
        .m_win_row  (m_win_row),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        window_t d;
        int      wr;
        int      wc;
    } exp_t;

    int      checks = 0;
    int      errors = 0;
    exp_t    exp_q[$];
    pixel_t  img [NP];
    int      pos = 0;
    int      fd_exp = 0;
    bit      hold_prev = 0;
    window_t prev_data = '0;
    int      prev_wc = 0;
    int      prev_wr = 0;
    int      win_cnt = 0;
    int      fd_cnt = 0;
    bit      stall_seen = 0;
    window_t first_win = '0;
    window_t acc_or = '0;
    window_t acc_and = '1;
    int      last_wr = 0;
    int      last_wc = 0;
    int      mr_mode = 0;
    int      hold_cnt = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic chkw(input string nm, input window_t act, input window_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic window_t cut_window(input int wr, input int wc);
        window_t w = '0;
        for (int c = 0; c < 6; c++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    w[((c * 9) + r * 3 + k) * 6 +: 6] =
                        img[(wr * 3 + r) * W + wc * 3 + k][c * 6 +: 6];
        return w;
    endfunction

    // Per-cycle compare against the frame model, away from the clock edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pos = 0;
            fd_exp = 0;
            hold_prev = 0;
        end else begin
            chk("s_ready", int'(s_ready), int'(!(m_valid && !m_ready)));
            chk("frame_done", int'(frame_done), fd_exp);
            if (hold_prev) begin
                chk("hold_valid", int'(m_valid), 1);
                chkw("hold_data", m_data, prev_data);
                chk("hold_col", int'(m_win_col), prev_wc);
                chk("hold_row", int'(m_win_row), prev_wr);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chkw("win_data", m_data, e.d);
                    chk("win_col", int'(m_win_col), e.wc);
                    chk("win_row", int'(m_win_row), e.wr);
                end
                if (win_cnt == 0) first_win = m_data;
                acc_or  = acc_or | m_data;
                acc_and = acc_and & m_data;
                last_wr = int'(m_win_row);
                last_wc = int'(m_win_col);
                win_cnt++;
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
            prev_wc   = int'(m_win_col);
            prev_wr   = int'(m_win_row);
            if (frame_done) fd_cnt++;
            if (s_valid && !s_ready) stall_seen = 1;
            fd_exp = 0;
            if (s_valid && s_ready) begin
                int r;
                int c;
                if (s_sof) pos = 0;
                img[pos] = s_data;
                r = pos / W;
                c = pos % W;
                if (r % 3 == 2 && c % 3 == 2) begin
                    exp_t e;
                    e.wr = r / 3;
                    e.wc = c / 3;
                    e.d  = cut_window(e.wr, e.wc);
                    exp_q.push_back(e);
                end
                fd_exp = (pos == NP - 1) ? 1 : 0;
                pos = (pos + 1) % NP;
            end
        end
    end

    // Consumer readiness: always, random, or a 20-cycle hold on the first window.
    always begin
        @(posedge clk);
        #1;
        case (mr_mode)
            1: m_ready = 1'($urandom_range(1));
            2: begin
                if (hold_cnt >= 20) begin
                    m_ready = 1'b1;
                end else if (m_valid) begin
                    m_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    m_ready = 1'b0;
                end
            end
            default: m_ready = 1'b1;
        endcase
    end

    task automatic push_pix(input pixel_t d, input logic sof);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > 1000) begin
                $display("FAIL push_timeout actual=stalled required=accept");
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // kind 0: value = pixel index mod 64 per channel, 1: random, 2: channel 5 only
    task automatic stream(input int n, input int kind, input bit sof0, input bit gaps);
        for (int i = 0; i < n; i++) begin
            pixel_t d;
            case (kind)
                1: d = 36'({$urandom(), $urandom()});
                2: d = {6'h3F, 30'h0};
                default: d = {6{6'(i % 64)}};
            endcase
            if (gaps && $urandom_range(1) == 0) begin
                @(posedge clk);
                #1;
            end
            push_pix(d, sof0 && i == 0);
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) begin
                done = 1;
                break;
            end
        end
        chk("drain", int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        win_cnt = 0;
        fd_cnt  = 0;
        acc_or  = '0;
        acc_and = '1;
    endtask

    initial begin
        window_t lit;
        window_t m5;
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        window_t lit;
        window_t m5;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_m_valid", int'(m_valid), 0);
        chkw("rst_m_data", m_data, '0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_win_col", int'(m_win_col), 0);
        chk("rst_win_row", int'(m_win_row), 0);

        // 1: one frame, consumer always ready
        clr_stats();
        mr_mode = 0;
        stream(NP, 0, 1'b1, 1'b0);
        drain();
        chk("t1_windows", win_cnt, 16);
        chk("t1_frame_done", fd_cnt, 1);
        lit = '0;
        for (int c = 0; c < 6; c++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    lit[((c * 9) + r * 3 + k) * 6 +: 6] = 6'(r * 12 + k);
        chkw("t1_window00_literal", first_win, lit);

        // 2: consumer stalls 20 cycles on the first window
        clr_stats();
        stall_seen = 0;
        hold_cnt = 0;
        mr_mode = 2;
        stream(NP, 0, 1'b0, 1'b0);
        drain();
        chk("t2_windows", win_cnt, 16);
        chk("t2_stall_seen", int'(stall_seen), 1);
        chk("t2_frame_done", fd_cnt, 1);

        // 3: random input gaps and random consumer over three frames
        clr_stats();
        mr_mode = 1;
        for (int f = 0; f < 3; f++) stream(NP, 1, 1'b1, 1'b1);
        drain();
        mr_mode = 0;
        chk("t3_windows", win_cnt, 48);
        chk("t3_frame_done", fd_cnt, 3);
        chk("t3_last_index", win_index(last_wr, last_wc, 4), 15);

        // 4: abort after 40 pixels; band 0 (pixels 0..35) already yields 4 windows
        clr_stats();
        stream(40, 0, 1'b1, 1'b0);
        stream(NP, 0, 1'b1, 1'b0);
        drain();
        chk("t4_windows", win_cnt, 20);
        chk("t4_frame_done", fd_cnt, 1);

        // 5: reset one cycle right after pixel 29 completes window (0,1)
        clr_stats();
        stream(30, 0, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t5_rst_valid", int'(m_valid), 0);
        chkw("t5_rst_data", m_data, '0);
        clr_stats();
        stream(NP, 0, 1'b0, 1'b0);
        drain();
        chk("t5_windows", win_cnt, 16);
        chk("t5_frame_done", fd_cnt, 1);

        // 6: only channel 5 carries data
        clr_stats();
        stream(NP, 2, 1'b1, 1'b0);
        drain();
        m5 = '0;
        m5[270 +: 54] = '1;
        chk("t6_windows", win_cnt, 16);
        chkw("t6_or", acc_or, m5);
        chkw("t6_and", acc_and, m5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
